chaos_sbox_gen: RTL and testbench

- Generates a key-dependent 8-bit bijective S-box from a fixed-point logistic map, x' = r·x·(1−x).
- Emits exactly 256 distinct bytes, one per write strobe.
- Sits directly upstream of the S-box storage stage: out_valid drives its enable_write, out_data drives its data_in.
- Duplicates are rejected with a 256-bit used-bitmap. A bounded linear-scan fallback guarantees termination.

---
 rtl/chaos_pkg.sv | 27 ++
 rtl/logistic_step.sv | 63 ++++++
 rtl/chaos_sbox_gen.sv | 138 +++++++++++++
 tb/tb_chaos_sbox_gen.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chaos_pkg.sv
// ---------------------------------------------------------------------------
// chaos_pkg
// Shared definitions for the chaotic S-box generator and its fixed-point
// logistic-map datapath.
//   X_W          : width of the map state x, Q0.16
//   R_FRAC       : fractional bits of the coefficient r, Q2.14
//   DEFAULT_SEED : substitute seed and degenerate-orbit kick constant
//   SBOX_SIZE    : number of entries in a complete byte S-box
//   state_t      : controller states
// ---------------------------------------------------------------------------
package chaos_pkg;

    localparam int              X_W          = 16;
    localparam int              R_FRAC       = 14;
    localparam int              SBOX_SIZE    = 256;
    localparam logic [X_W-1:0]  DEFAULT_SEED = 16'h5A5A;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL1  = 3'd1,
        MUL2  = 3'd2,
        CHECK = 3'd3,
        SCAN  = 3'd4,
        DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/logistic_step.sv
// ---------------------------------------------------------------------------
// logistic_step
// Two-stage registered fixed-point logistic map x' = r*x*(1-x).
//   clk    : rising-edge clock
//   rst    : asynchronous active-low reset (clears x, r, p)
//   load   : capture x_init and r_init (takes priority over steps)
//   x_init : starting x, Q0.16
//   r_init : coefficient r, Q2.14
//   step1  : register p = x*(1-x), Q0.16
//   step2  : register x = saturate((p*r) >> 14) with degenerate kick
//   x      : current map state, Q0.16
// ---------------------------------------------------------------------------
module logistic_step import chaos_pkg::*; #(
    parameter logic [X_W-1:0] KICK = DEFAULT_SEED
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [X_W-1:0]  x_init,
    input  logic [X_W-1:0]  r_init,
    input  logic            step1,
    input  logic            step2,
    output logic [X_W-1:0]  x
);

    logic [X_W-1:0] r;
    logic [X_W-1:0] p;
    logic [32:0]    sq;
    logic [16:0]    unused_sq;
    logic [31:0]    pr;
    logic [31:0]    pr_shift;
    logic [X_W-1:0] xn_sat;
    logic [X_W-1:0] xn;

    // 1-x is 65536-x, which needs 17 bits when x == 0; the product peaks at
    // 2^30, so bits [31:16] are exactly the Q0.16 result.
    assign sq        = {17'b0, x} * (33'h1_0000 - {17'b0, x});
    assign unused_sq = {sq[32], sq[15:0]};

    assign pr       = {16'b0, p} * {16'b0, r};
    assign pr_shift = pr >> R_FRAC;
    assign xn_sat   = (|pr_shift[31:16]) ? 16'hFFFF : pr_shift[15:0];

    // A zero or fixed-point orbit would emit the same byte forever; kick it.
    assign xn = (xn_sat == '0 || xn_sat == x) ? (xn_sat ^ KICK) : xn_sat;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x <= '0;
            r <= '0;
            p <= '0;
        end else if (load) begin
            x <= x_init;
            r <= r_init;
        end else begin
            if (step1) p <= sq[31:16];
            if (step2) x <= xn;
        end
    end

endmodule

// File: rtl/chaos_sbox_gen.sv
// ---------------------------------------------------------------------------
// chaos_sbox_gen
// Emits a key-dependent bijective 8-bit S-box, one byte per strobe, drawn
// from a logistic-map orbit. Duplicates are rejected against a used-bitmap;
// after REJECT_LIMIT consecutive duplicates a linear scan picks the next
// free entry so the table always completes.
//   clk       : rising-edge clock
//   rst       : asynchronous active-low reset
//   start     : one-cycle pulse, accepted in IDLE or DONE only
//   seed      : initial x, Q0.16 (0 and FFFF replaced by DEFAULT_SEED)
//   r_coef    : map coefficient r, Q2.14
//   out_valid : one-cycle strobe per emitted byte (write enable downstream)
//   out_data  : emitted byte, meaningful while out_valid = 1
//   busy      : high from accepted start until DONE
//   done      : high in DONE until the next accepted start
//   count     : bytes emitted so far, 0..256
// ---------------------------------------------------------------------------
module chaos_sbox_gen #(
    parameter int                            REJECT_LIMIT = 16,
    parameter logic [chaos_pkg::X_W-1:0]     DEFAULT_SEED = chaos_pkg::DEFAULT_SEED
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [chaos_pkg::X_W-1:0]   seed,
    input  logic [chaos_pkg::X_W-1:0]   r_coef,
    output logic                        out_valid,
    output logic [7:0]                  out_data,
    output logic                        busy,
    output logic                        done,
    output logic [8:0]                  count
);

    import chaos_pkg::*;

    state_t               state;
    logic [SBOX_SIZE-1:0] used;
    logic [7:0]           rejects;
    logic [7:0]           ptr;
    logic [X_W-1:0]       x;
    logic [X_W-1:0]       seed_eff;
    logic [7:0]           cand;
    logic                 load;
    logic                 emit_en;
    logic [7:0]           emit_byte;

    assign load     = start && (state == IDLE || state == DONE);
    assign seed_eff = (seed == '0 || seed == '1) ? DEFAULT_SEED : seed;
    assign cand     = x[15:8] ^ x[7:0];

    logistic_step #(.KICK(DEFAULT_SEED)) u_step (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .x_init (seed_eff),
        .r_init (r_coef),
        .step1  (state == MUL1),
        .step2  (state == MUL2),
        .x      (x)
    );

    // CHECK offers the map candidate, SCAN offers the scan pointer; both
    // emit through the same path below.
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        emit_en   = 1'b0;
        emit_byte = cand;
        case (state)
            CHECK: emit_en = !used[cand];
            SCAN: begin
                emit_en   = !used[ptr];
                emit_byte = ptr;
            end
            default: ;
        endcase
    end

    // NOTE: the bitmap is a flop vector, not a RAM, so it takes the async
    // reset like the rest of the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            used      <= '0;
            rejects   <= '0;
            ptr       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            count     <= '0;
        end else begin
            out_valid <= 1'b0;
            if (load) begin
                used    <= '0;
                count   <= '0;
                rejects <= '0;
                done    <= 1'b0;
                busy    <= 1'b1;
                state   <= MUL1;
            end else if (emit_en) begin
                out_valid       <= 1'b1;
                out_data        <= emit_byte;
                used[emit_byte] <= 1'b1;
                count           <= count + 9'd1;
                rejects         <= '0;
                // The 256th strobe and DONE entry share one edge.
                if (count == 9'(SBOX_SIZE - 1)) begin
                    state <= DONE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end else begin
                    state <= MUL1;
                end
            end else begin
                case (state)
                    MUL1:  state <= MUL2;
                    MUL2:  state <= CHECK;
                    CHECK: begin
                        if (rejects == 8'(REJECT_LIMIT - 1)) begin
                            ptr     <= cand + 8'd1;
                            rejects <= '0;
                            state   <= SCAN;
                        end else begin
                            rejects <= rejects + 8'd1;
                            state   <= MUL1;
                        end
                    end
                    // count < 256 here, so a free entry always exists ahead.
                    SCAN:       ptr <= ptr + 8'd1;
                    IDLE, DONE: ;
                    default:    state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_chaos_sbox_gen.sv
// ---------------------------------------------------------------------------
// tb_chaos_sbox_gen
// Scoreboard bench: each run's expected byte stream (value, strobe cycle
// relative to the start edge, running count) is produced by a behavioural
// logistic-map model and queued; per-DUT monitors pop and compare on every
// strobe. A second instance uses REJECT_LIMIT = 1 to force the scan path.
// ---------------------------------------------------------------------------
module tb_chaos_sbox_gen;

    import chaos_pkg::*;

    typedef struct {
        logic [7:0] data;
        int         rel;
        int         cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start_a = 1'b0, start_b = 1'b0;
    logic [15:0] seed_a = '0, r_a = '0, seed_b = '0, r_b = '0;
    logic        ov_a, ov_b, busy_a, busy_b, done_a, done_b;
    logic [7:0]  od_a, od_b;
    logic [8:0]  cnt_a, cnt_b;

    chaos_sbox_gen dut_a (
        .clk(clk), .rst(rst), .start(start_a), .seed(seed_a), .r_coef(r_a),
        .out_valid(ov_a), .out_data(od_a), .busy(busy_a), .done(done_a), .count(cnt_a)
    );

    chaos_sbox_gen #(.REJECT_LIMIT(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .seed(seed_b), .r_coef(r_b),
        .out_valid(ov_b), .out_data(od_b), .busy(busy_b), .done(done_b), .count(cnt_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    exp_t model_seq[256];

    task automatic run_model(input int seed, input int r, input int limit);
        longint x, p, xn;
        int     t, cnt, rej, cand, ptr, k;
        bit     taken[256];
        for (int i = 0; i < 256; i++) taken[i] = 1'b0;
        x   = (seed == 0 || seed == 'hFFFF) ? 'h5A5A : seed;
        t   = 3;
        cnt = 0;
        rej = 0;
        while (cnt < 256) begin
            p  = (x * (65536 - x)) / 65536;
            xn = (p * r) / 16384;
            if (xn > 65535) xn = 65535;
            if (xn == 0 || xn == x) xn = xn ^ 'h5A5A;
            x    = xn;
            cand = int'((x / 256) ^ (x % 256));
            if (!taken[cand]) begin
                model_seq[cnt] = '{data: 8'(cand), rel: t, cnt: cnt + 1};
                taken[cand] = 1'b1;
                cnt++;
                rej = 0;
                t += 3;
            end else if (rej == limit - 1) begin
                rej = 0;
                ptr = (cand + 1) % 256;
                k   = 1;
                while (taken[ptr]) begin
                    ptr = (ptr + 1) % 256;
                    k++;
                end
                t += k;
                model_seq[cnt] = '{data: 8'(ptr), rel: t, cnt: cnt + 1};
                taken[ptr] = 1'b1;
                cnt++;
                t += 3;
            end else begin
                rej++;
                t += 3;
            end
        end
    endtask

    // ---------------- scoreboards / monitors ----------------
    exp_t q_a[$], q_b[$];
    exp_t e_a, e_b;
    int   start_cyc_a = 0, start_cyc_b = 0;
    int   rx_a = 0, rx_b = 0, uniq_a = 0, uniq_b = 0;
    bit   seen_a[256], seen_b[256];
    bit   prev_ov_a = 1'b0, prev_ov_b = 1'b0;
    logic [7:0] first_a = '0;
    int   first_rel_a = 0;
    bit   saw_scan_b = 1'b0;

    always @(negedge clk) begin
        if (rst && ov_a) begin
            check("a_no_adjacent_strobe", 64'(prev_ov_a), 64'd0);
            if (rx_a == 0) begin
                first_a     = od_a;
                first_rel_a = cyc - start_cyc_a;
            end
            if (q_a.size() == 0) begin
                check("a_unexpected_strobe", 64'd1, 64'd0);
            end else begin
                e_a = q_a.pop_front();
                check("a_data",  64'(od_a), 64'(e_a.data));
                check("a_cycle", 64'(cyc - start_cyc_a), 64'(e_a.rel));
                check("a_count", 64'(cnt_a), 64'(e_a.cnt));
            end
            if (!seen_a[od_a]) uniq_a++;
            seen_a[od_a] = 1'b1;
            rx_a++;
        end
        prev_ov_a = ov_a;
    end

    always @(negedge clk) begin
        if (rst && dut_b.state == SCAN) saw_scan_b = 1'b1;
        if (rst && ov_b) begin
            check("b_no_adjacent_strobe", 64'(prev_ov_b), 64'd0);
            if (q_b.size() == 0) begin
                check("b_unexpected_strobe", 64'd1, 64'd0);
            end else begin
                e_b = q_b.pop_front();
                check("b_data",  64'(od_b), 64'(e_b.data));
                check("b_cycle", 64'(cyc - start_cyc_b), 64'(e_b.rel));
                check("b_count", 64'(cnt_b), 64'(e_b.cnt));
            end
            if (!seen_b[od_b]) uniq_b++;
            seen_b[od_b] = 1'b1;
            rx_b++;
        end
        prev_ov_b = ov_b;
    end

    // ---------------- helpers ----------------
    task automatic clear_a();
        q_a.delete();
        for (int i = 0; i < 256; i++) seen_a[i] = 1'b0;
        uniq_a = 0;
        rx_a   = 0;
    endtask

    task automatic start_run_a(input logic [15:0] s, input logic [15:0] r);
        run_model(int'(s), int'(r), 16);
        clear_a();
        for (int i = 0; i < 256; i++) q_a.push_back(model_seq[i]);
        @(negedge clk);
        seed_a  = s;
        r_a     = r;
        start_a = 1'b1;
        @(negedge clk);
        start_a     = 1'b0;
        start_cyc_a = cyc;
    endtask

    task automatic wait_rx_a(input int n, input string name);
        int k = 0;
        while (rx_a < n && k < 40000) begin
            @(posedge clk);
            k++;
        end
        check({name, "_strobe_timeout"}, 64'(rx_a >= n), 64'd1);
    endtask

    task automatic check_complete_a(input string name);
        @(negedge clk);
        check({name, "_done"},   64'(done_a), 64'd1);
        check({name, "_busy"},   64'(busy_a), 64'd0);
        check({name, "_count"},  64'(cnt_a),  64'd256);
        check({name, "_unique"}, 64'(uniq_a), 64'd256);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear with no clock edge.
    task automatic abort_a(input string name);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check({name, "_rst_valid"}, 64'(ov_a),   64'd0);
        check({name, "_rst_data"},  64'(od_a),   64'd0);
        check({name, "_rst_busy"},  64'(busy_a), 64'd0);
        check({name, "_rst_done"},  64'(done_a), 64'd0);
        check({name, "_rst_count"}, 64'(cnt_a),  64'd0);
        clear_a();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #(90000 * 10);
        $display("FAIL watchdog: simulation exceeded its cycle budget");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] s, r;
        int          k;

        #3 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_a_valid", 64'(ov_a),   64'd0);
        check("reset_a_data",  64'(od_a),   64'd0);
        check("reset_a_busy",  64'(busy_a), 64'd0);
        check("reset_a_done",  64'(done_a), 64'd0);
        check("reset_a_count", 64'(cnt_a),  64'd0);
        check("reset_b_busy",  64'(busy_b), 64'd0);
        check("reset_b_count", 64'(cnt_b),  64'd0);
        rst = 1'b1;

        // Forced-scan instance: expectations queued before both runs start.
        run_model(32'h8000, 32'h4000, 1);
        q_b.delete();
        for (int i = 0; i < 256; i++) q_b.push_back(model_seq[i]);

        fork
            begin
                start_run_a(16'h8000, 16'hFF5C);
                check("t1_busy_after_start", 64'(busy_a), 64'd1);
                wait_rx_a(1, "t1");
                check("t1_first_byte",    64'(first_a),     64'hA3);
                check("t1_first_latency", 64'(first_rel_a), 64'd3);
                wait_rx_a(256, "t2");
                check_complete_a("t2");
                check("t2_queue_drained", 64'(q_a.size()), 64'd0);
            end
            begin
                @(negedge clk);
                seed_b  = 16'h8000;
                r_b     = 16'h4000;
                start_b = 1'b1;
                @(negedge clk);
                start_b     = 1'b0;
                start_cyc_b = cyc;
                k = 0;
                while (rx_b < 256 && k < 60000) begin
                    @(posedge clk);
                    k++;
                end
                check("t3_strobe_timeout", 64'(rx_b >= 256), 64'd1);
                @(negedge clk);
                check("t3_done",       64'(done_b),     64'd1);
                check("t3_count",      64'(cnt_b),      64'd256);
                check("t3_unique",     64'(uniq_b),     64'd256);
                check("t3_scan_seen",  64'(saw_scan_b), 64'd1);
            end
        join

        // Restart from DONE with a random key.
        s = 16'($urandom_range(1, 16'hFFFE));
        r = 16'($urandom_range(16'hE000, 16'hFFFF));
        start_run_a(s, r);
        check("t6_done_dropped", 64'(done_a), 64'd0);
        check("t6_count_zero",   64'(cnt_a),  64'd0);
        check("t6_busy",         64'(busy_a), 64'd1);
        wait_rx_a(256, "t6");
        check_complete_a("t6");

        // Reserved seeds must reproduce the DEFAULT_SEED stream.
        r = 16'($urandom_range(16'hE000, 16'hFFFF));
        start_run_a(16'h0000, r);
        wait_rx_a(30, "t4_seed0");
        abort_a("t4_seed0");
        start_run_a(16'hFFFF, r);
        wait_rx_a(30, "t4_seedffff");
        abort_a("t4_seedffff");
        start_run_a(16'h5A5A, r);
        wait_rx_a(30, "t4_seed5a5a");
        abort_a("t4_seed5a5a");

        // Start while busy is ignored; reset abandons; restart reproduces.
        s = 16'($urandom_range(1, 16'hFFFE));
        r = 16'($urandom_range(16'hE000, 16'hFFFF));
        start_run_a(s, r);
        wait_rx_a(10, "t5_pre");
        @(negedge clk);
        seed_a  = ~s;
        r_a     = 16'h4000;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        seed_a  = s;
        r_a     = r;
        wait_rx_a(100, "t5_mid");
        abort_a("t5");
        start_run_a(s, r);
        wait_rx_a(256, "t5_rerun");
        check_complete_a("t5_rerun");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
